// File: rtl/arp_rx_parser_if.sv
// ARP receive parser bus: input byte stream plus parsed-packet output.
//
// Handshake: the byte stream has no back-pressure; a byte is consumed on
// every rising edge where data_valid=1, and data_last and eth_type_arp_valid
// only mean something on those edges. On the output side, once m_valid=1 the
// producer holds m_valid and every m_* field stable until a rising edge with
// m_valid=1 and m_ready=1. The transfer completes on that edge. m_ready may
// change freely and does not depend on m_valid.
interface arp_rx_parser_if;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_last;
    logic        eth_type_arp_valid;
    logic        m_valid;
    logic        m_ready;
    logic        m_oper;
    logic [47:0] m_sha;
    logic [31:0] m_spa;
    logic [47:0] m_tha;
    logic [31:0] m_tpa;

    // Source side: drives the byte stream and consumes parsed packets
    modport master (
        output data_in, data_valid, data_last, eth_type_arp_valid, m_ready,
        input  m_valid, m_oper, m_sha, m_spa, m_tha, m_tpa
    );

    // Parser side
    modport slave (
        input  data_in, data_valid, data_last, eth_type_arp_valid, m_ready,
        output m_valid, m_oper, m_sha, m_spa, m_tha, m_tpa
    );
endinterface

// File: rtl/arp_rx_parser.sv
// ARP receive parser: walks the 28-byte ARP payload, validates the fixed
// header and the configured acceptance rules, and presents the sender and
// target addresses on a valid/ready output. Rejected packets raise a
// one-cycle drop strobe and bump a saturating counter.
module arp_rx_parser #(
    parameter int unsigned CHECK_TPA        = 1,
    parameter int unsigned ACCEPT_REPLY     = 1,
    parameter int unsigned REQUIRE_ZERO_THA = 0,
    parameter int unsigned CNT_W            = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       local_ip,
    arp_rx_parser_if.slave    io_arp,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [2:0]        o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SHA, S_SPA, S_THA, S_TPA, S_SKIP, S_DISCARD
    } state_t;

    state_t             r_state;
    logic [4:0]         r_idx;
    logic [7:0]         r_prev;
    logic               r_oper_cap;
    logic [47:0]        r_sha_cap;
    logic [31:0]        r_spa_cap;
    logic [47:0]        r_tha_cap;
    logic [23:0]        r_tpa_cap;
    logic               r_m_valid;
    logic               r_m_oper;
    logic [47:0]        r_m_sha;
    logic [31:0]        r_m_spa;
    logic [47:0]        r_m_tha;
    logic [31:0]        r_m_tpa;
    logic               r_drop_pulse;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_in_pkt;
    logic               w_parse;
    logic [4:0]         w_idx;
    logic [4:0]         w_idx_nxt;
    logic [15:0]        w_pair;
    logic               w_err;
    logic               w_good;
    logic               w_load;
    logic               w_drop;
    state_t             w_field_state;

    // Byte-level decode: which index is consumed now and whether it breaks the packet
    always_comb begin
        w_in_pkt  = (r_state == S_HDR) || (r_state == S_SHA) || (r_state == S_SPA) ||
                    (r_state == S_THA) || (r_state == S_TPA);
        w_idx     = (r_state == S_IDLE) ? 5'd0 : r_idx;
        w_idx_nxt = w_idx + 5'd1;
        w_parse   = io_arp.data_valid &&
                    (((r_state == S_IDLE) && io_arp.eth_type_arp_valid) || w_in_pkt);
        w_pair    = {r_prev, io_arp.data_in};
        w_err     = 1'b0;
        // Multi-byte fields are judged on the byte that completes them
        case (w_idx)
            5'd1:    w_err = (w_pair != 16'h0001);
            5'd3:    w_err = (w_pair != 16'h0800);
            5'd4:    w_err = (io_arp.data_in != 8'h06);
            5'd5:    w_err = (io_arp.data_in != 8'h04);
            5'd7:    w_err = !((w_pair == 16'h0001) ||
                               ((w_pair == 16'h0002) && (ACCEPT_REPLY != 0)));
            5'd23:   w_err = (REQUIRE_ZERO_THA != 0) && !r_oper_cap &&
                             ({r_tha_cap[39:0], io_arp.data_in} != 48'd0);
            5'd27:   w_err = (CHECK_TPA != 0) &&
                             ({r_tpa_cap, io_arp.data_in} != local_ip);
            default: w_err = 1'b0;
        endcase
        // A frame that ends before the last ARP byte is truncated
        if (io_arp.data_last && (w_idx != 5'd27)) begin
            w_err = 1'b1;
        end
        if (!w_parse) begin
            w_err = 1'b0;
        end
        w_good = w_parse && !w_err && (w_idx == 5'd27);
        // A finished packet only loads if the output slot is free or draining now
        w_load = w_good && (!r_m_valid || io_arp.m_ready);
        w_drop = (w_parse && w_err) || (w_good && !w_load);
        if (w_idx_nxt < 5'd8) begin
            w_field_state = S_HDR;
        end else if (w_idx_nxt < 5'd14) begin
            w_field_state = S_SHA;
        end else if (w_idx_nxt < 5'd18) begin
            w_field_state = S_SPA;
        end else if (w_idx_nxt < 5'd24) begin
            w_field_state = S_THA;
        end else begin
            w_field_state = S_TPA;
        end
    end

    // Field capture: shift each accepted byte into the register of its field
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_prev     <= 8'd0;
            r_oper_cap <= 1'b0;
            r_sha_cap  <= 48'd0;
            r_spa_cap  <= 32'd0;
            r_tha_cap  <= 48'd0;
            r_tpa_cap  <= 24'd0;
        end else if (w_parse) begin
            r_prev <= io_arp.data_in;
            if (w_idx == 5'd7) begin
                r_oper_cap <= io_arp.data_in[1];
            end
            if ((w_idx >= 5'd8) && (w_idx <= 5'd13)) begin
                r_sha_cap <= {r_sha_cap[39:0], io_arp.data_in};
            end
            if ((w_idx >= 5'd14) && (w_idx <= 5'd17)) begin
                r_spa_cap <= {r_spa_cap[23:0], io_arp.data_in};
            end
            if ((w_idx >= 5'd18) && (w_idx <= 5'd23)) begin
                r_tha_cap <= {r_tha_cap[39:0], io_arp.data_in};
            end
            if ((w_idx >= 5'd24) && (w_idx <= 5'd26)) begin
                r_tpa_cap <= {r_tpa_cap[15:0], io_arp.data_in};
            end
        end
    end

    // Packet FSM with registered output slot and drop accounting
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_idx        <= 5'd0;
            r_m_valid    <= 1'b0;
            r_m_oper     <= 1'b0;
            r_m_sha      <= 48'd0;
            r_m_spa      <= 32'd0;
            r_m_tha      <= 48'd0;
            r_m_tpa      <= 32'd0;
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end

            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_oper  <= r_oper_cap;
                r_m_sha   <= r_sha_cap;
                r_m_spa   <= r_spa_cap;
                r_m_tha   <= r_tha_cap;
                r_m_tpa   <= {r_tpa_cap, io_arp.data_in};
            end else if (io_arp.m_ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE, S_HDR, S_SHA, S_SPA, S_THA, S_TPA: begin
                    if (w_parse) begin
                        if (w_drop) begin
                            r_state <= io_arp.data_last ? S_IDLE : S_DISCARD;
                        end else if (w_idx == 5'd27) begin
                            r_state <= io_arp.data_last ? S_IDLE : S_SKIP;
                        end else begin
                            r_state <= w_field_state;
                            r_idx   <= w_idx_nxt;
                        end
                    end
                end
                S_SKIP, S_DISCARD: begin
                    if (io_arp.data_valid && io_arp.data_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_arp.m_valid = r_m_valid;
    assign io_arp.m_oper  = r_m_oper;
    assign io_arp.m_sha   = r_m_sha;
    assign io_arp.m_spa   = r_m_spa;
    assign io_arp.m_tha   = r_m_tha;
    assign io_arp.m_tpa   = r_m_tpa;
    assign drop_pulse     = r_drop_pulse;
    assign drop_cnt       = r_drop_cnt;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_arp_rx_parser.sv
// Bench for arp_rx_parser: directed scenarios plus randomized packets, with
// a packet-level reference model feeding an expected queue that a monitor
// drains whenever the parser hands over a packet.
module tb_arp_rx_parser;
    localparam logic [31:0] LOCAL_IP = 32'hC0A80114;   // 192.168.1.20
    localparam logic [2:0]  ST_IDLE    = 3'd0;
    localparam logic [2:0]  ST_DISCARD = 3'd7;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        drop_a, drop_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic [2:0]  st_a, st_b;

    arp_rx_parser_if bus_a ();
    arp_rx_parser_if bus_b ();

    // Second instance sees the identical stream; only its counter width differs
    assign bus_b.data_in            = bus_a.data_in;
    assign bus_b.data_valid         = bus_a.data_valid;
    assign bus_b.data_last          = bus_a.data_last;
    assign bus_b.eth_type_arp_valid = bus_a.eth_type_arp_valid;
    assign bus_b.m_ready            = bus_a.m_ready;

    arp_rx_parser dut_a (
        .aclk(aclk), .aresetn(aresetn), .local_ip(LOCAL_IP), .io_arp(bus_a),
        .drop_pulse(drop_a), .drop_cnt(cnt_a), .o_dbg_state(st_a)
    );

    arp_rx_parser #(.CNT_W(2)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .local_ip(LOCAL_IP), .io_arp(bus_b),
        .drop_pulse(drop_b), .drop_cnt(cnt_b), .o_dbg_state(st_b)
    );

    // Clock
    always #5 aclk = ~aclk;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [160:0]   exp_q[$];
    int             exp_drops = 0;
    int             seen_a = 0;
    int             seen_b = 0;
    logic [7:0]     pkt[$];

    task automatic check(input string name, input logic [160:0] act, input logic [160:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Build an ARP payload of len bytes (truncated or zero/random padded)
    task automatic make_pkt(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                            input logic [47:0] tha, input logic [31:0] tpa, input int len);
        pkt.delete();
        pkt.push_back(8'h00); pkt.push_back(8'h01);
        pkt.push_back(8'h08); pkt.push_back(8'h00);
        pkt.push_back(8'h06); pkt.push_back(8'h04);
        pkt.push_back(oper[15:8]); pkt.push_back(oper[7:0]);
        for (int k = 5; k >= 0; k--) pkt.push_back(sha[k*8 +: 8]);
        for (int k = 3; k >= 0; k--) pkt.push_back(spa[k*8 +: 8]);
        for (int k = 5; k >= 0; k--) pkt.push_back(tha[k*8 +: 8]);
        for (int k = 3; k >= 0; k--) pkt.push_back(tpa[k*8 +: 8]);
        while (pkt.size() < len) pkt.push_back(8'($urandom_range(0, 255)));
        while (pkt.size() > len) void'(pkt.pop_back());
    endtask

    // Reference: acceptance decided from the whole byte list
    function automatic bit model_good();
        logic [15:0] oper;
        if (pkt.size() < 28) return 1'b0;
        if ({pkt[0], pkt[1]} != 16'h0001) return 1'b0;
        if ({pkt[2], pkt[3]} != 16'h0800) return 1'b0;
        if (pkt[4] != 8'h06 || pkt[5] != 8'h04) return 1'b0;
        oper = {pkt[6], pkt[7]};
        if (oper != 16'd1 && oper != 16'd2) return 1'b0;
        if ({pkt[24], pkt[25], pkt[26], pkt[27]} != LOCAL_IP) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [160:0] model_fields();
        logic oper_bit;
        oper_bit = ({pkt[6], pkt[7]} == 16'd2);
        return {oper_bit,
                pkt[8], pkt[9], pkt[10], pkt[11], pkt[12], pkt[13],
                pkt[14], pkt[15], pkt[16], pkt[17],
                pkt[18], pkt[19], pkt[20], pkt[21], pkt[22], pkt[23],
                pkt[24], pkt[25], pkt[26], pkt[27]};
    endfunction

    // Record what the current packet must produce; busy = output slot held
    task automatic issue(input bit busy);
        if (model_good() && !busy) exp_q.push_back(model_fields());
        else exp_drops++;
    endtask

    // Driver: mode 1 checks 1-cycle output latency, mode 2 checks DISCARD after byte 27
    task automatic send_pkt(input int gmin, input int gmax, input int mode, input bit stray);
        for (int i = 0; i < pkt.size(); i++) begin
            int g;
            g = $urandom_range(gmax, gmin);
            repeat (g) begin @(posedge aclk); #1; end
            bus_a.data_in            = pkt[i];
            bus_a.data_valid         = 1'b1;
            bus_a.data_last          = (i == pkt.size() - 1);
            bus_a.eth_type_arp_valid = (i == 0) || (stray && ($urandom_range(0, 7) == 0));
            if (mode == 1 && i == 27) check("m_valid_before_byte27", bus_a.m_valid, 0);
            @(posedge aclk); #1;
            bus_a.data_valid         = 1'b0;
            bus_a.data_last          = 1'b0;
            bus_a.eth_type_arp_valid = 1'b0;
            if (mode == 1 && i == 27) check("m_valid_latency", bus_a.m_valid, 1);
            if (mode == 2 && i == 27) check("discard_state", st_a, ST_DISCARD);
        end
    endtask

    // Bytes outside a packet: must be ignored while idle
    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.data_in    = 8'($urandom_range(0, 255));
            bus_a.data_valid = 1'b1;
            bus_a.data_last  = 1'($urandom_range(0, 1));
            @(posedge aclk); #1;
            bus_a.data_valid = 1'b0;
            bus_a.data_last  = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic check_drops(input string tag);
        check({tag, "_drop_cnt"}, cnt_a, exp_drops[15:0]);
        check({tag, "_drop_pulses"}, seen_a, exp_drops);
    endtask

    // Monitor: count drop strobes and compare every handed-over packet
    always @(negedge aclk) begin
        if (aresetn) begin
            if (drop_a) seen_a++;
            if (drop_b) seen_b++;
            if (bus_a.m_valid && bus_a.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none",
                             {bus_a.m_oper, bus_a.m_sha, bus_a.m_spa, bus_a.m_tha, bus_a.m_tpa});
                end else begin
                    logic [160:0] e;
                    e = exp_q.pop_front();
                    check("m_fields", {bus_a.m_oper, bus_a.m_sha, bus_a.m_spa, bus_a.m_tha, bus_a.m_tpa}, e);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Stimulus
    initial begin
        logic [47:0] sha_a, sha_b;
        bus_a.data_in = 8'd0;
        bus_a.data_valid = 1'b0;
        bus_a.data_last = 1'b0;
        bus_a.eth_type_arp_valid = 1'b0;
        bus_a.m_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_valid", bus_a.m_valid, 0);
        check("rst_m_sha", bus_a.m_sha, 0);
        check("rst_drop_cnt", cnt_a, 0);
        check("rst_state", st_a, ST_IDLE);
        aresetn = 1'b1;
        settle();

        // Basic request padded to 46 bytes
        make_pkt(16'd1, 48'h020000000001, 32'hC0A8010A, 48'd0, LOCAL_IP, 46);
        issue(1'b0);
        send_pkt(0, 0, 1, 1'b0);
        settle();
        check_drops("req");

        // Same request with 3 idle cycles before every byte
        issue(1'b0);
        send_pkt(3, 3, 1, 1'b0);
        settle();
        check_drops("gapped");

        // Wrong target IP: dropped, discards the tail, then a good packet
        make_pkt(16'd1, 48'h020000000001, 32'hC0A8010A, 48'd0, 32'hC0A80163, 46);
        issue(1'b0);
        send_pkt(0, 0, 2, 1'b0);
        settle();
        check_drops("bad_tpa");
        make_pkt(16'd2, 48'h0A0B0C0D0E0F, 32'h0A000001, 48'h112233445566, LOCAL_IP, 40);
        issue(1'b0);
        send_pkt(0, 1, 1, 1'b0);
        settle();

        // Bad PTYPE, then a frame ending at byte 12
        make_pkt(16'd1, 48'h020000000002, 32'hC0A8010B, 48'd0, LOCAL_IP, 46);
        pkt[2] = 8'h86;
        pkt[3] = 8'hDD;
        issue(1'b0);
        send_pkt(0, 0, 0, 1'b0);
        settle();
        check("ptype_state_idle", st_a, ST_IDLE);
        make_pkt(16'd1, 48'h020000000003, 32'hC0A8010C, 48'd0, LOCAL_IP, 13);
        issue(1'b0);
        send_pkt(0, 0, 0, 1'b0);
        settle();
        check("short_state_idle", st_a, ST_IDLE);
        check_drops("hdr_drops");

        // Back-pressure: first packet held, second dropped
        bus_a.m_ready = 1'b0;
        sha_a = 48'h02AABBCCDD01;
        sha_b = 48'h02AABBCCDD02;
        make_pkt(16'd1, sha_a, 32'hC0A80121, 48'd0, LOCAL_IP, 28);
        issue(1'b0);
        send_pkt(0, 0, 0, 1'b0);
        make_pkt(16'd2, sha_b, 32'hC0A80122, 48'h1, LOCAL_IP, 28);
        issue(1'b1);
        send_pkt(0, 0, 0, 1'b0);
        settle();
        check("bp_m_valid_held", bus_a.m_valid, 1);
        check("bp_m_sha_held", bus_a.m_sha, sha_a);
        check_drops("bp");
        bus_a.m_ready = 1'b1;
        @(posedge aclk); #1;
        check("bp_m_valid_after", bus_a.m_valid, 0);

        // Asynchronous reset in the middle of a packet
        make_pkt(16'd1, 48'h020000000004, 32'hC0A8010D, 48'd0, LOCAL_IP, 46);
        for (int i = 0; i < 16; i++) begin
            bus_a.data_in = pkt[i];
            bus_a.data_valid = 1'b1;
            bus_a.eth_type_arp_valid = (i == 0);
            if (i < 15) begin
                @(posedge aclk); #1;
            end
        end
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_m_valid", bus_a.m_valid, 0);
        check("arst_m_sha", bus_a.m_sha, 0);
        check("arst_drop_cnt", cnt_a, 0);
        check("arst_drop_pulse", drop_a, 0);
        check("arst_state", st_a, ST_IDLE);
        bus_a.data_valid = 1'b0;
        bus_a.eth_type_arp_valid = 1'b0;
        exp_drops = 0;
        seen_a = 0;
        seen_b = 0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        settle();
        make_pkt(16'd1, 48'h020000000005, 32'hC0A8010E, 48'd0, LOCAL_IP, 46);
        issue(1'b0);
        send_pkt(0, 0, 1, 1'b0);
        settle();
        check_drops("post_rst");

        // Five drops: narrow counter saturates at 3
        for (int n = 0; n < 5; n++) begin
            make_pkt(16'd1, 48'h020000000006, 32'hC0A8010F, 48'd0, LOCAL_IP, $urandom_range(1, 27));
            issue(1'b0);
            send_pkt(0, 1, 0, 1'b0);
        end
        settle();
        check_drops("sat");
        check("sat_cnt_w2", cnt_b, 3);
        check("sat_pulses_w2", seen_b, 5);

        // Randomized packets with corruption, gaps, stray start marks and junk
        for (int n = 0; n < 40; n++) begin
            int sel;
            logic [15:0] oper;
            oper = ($urandom_range(0, 1) == 0) ? 16'd1 : 16'd2;
            make_pkt(oper, {$urandom, $urandom}, $urandom, {$urandom, $urandom},
                     LOCAL_IP, $urandom_range(28, 50));
            sel = $urandom_range(0, 11);
            case (sel)
                0: pkt[1] = 8'h02;
                1: begin pkt[2] = 8'h86; pkt[3] = 8'hDD; end
                2: pkt[4] = 8'h05;
                3: pkt[5] = 8'h10;
                4: pkt[7] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h03;
                5: pkt[26] = pkt[26] ^ 8'h40;
                6: while (pkt.size() > 27 - $urandom_range(0, 20)) void'(pkt.pop_back());
                default: ;
            endcase
            issue(1'b0);
            send_junk($urandom_range(0, 3));
            send_pkt(0, 2, 0, 1'b1);
        end
        settle();
        check_drops("rand");
        check("rand_cnt_w2", cnt_b, (exp_drops > 3) ? 3 : exp_drops);

        // Drain
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge aclk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arp_rx_parser.md
ARP_RX_PARSER -- requirements
Module: arp_rx_parser

Interface
REQ-001 SHALL have parameter CHECK_TPA, default 1: drop packets whose target IP differs from local_ip.
REQ-002 SHALL have parameter ACCEPT_REPLY, default 1: 0 drops OPER=2 packets.
REQ-003 SHALL have parameter REQUIRE_ZERO_THA, default 0: 1 drops requests whose target MAC is non-zero.
REQ-004 SHALL have parameter CNT_W, default 16: width of drop_cnt.
REQ-005 SHALL have ports (name direction width meaning):
- aclk  in  1  clock, rising edge.
- aresetn  in  1  reset; one clock, asynchronous assert, active-low.
- data_in  in  8  ARP payload byte.
- data_valid  in  1  data_in valid this cycle.
- data_last  in  1  last byte of frame, qualified by data_valid.
- eth_type_arp_valid  in  1  marks byte 0 of the ARP payload, qualified by data_valid.
- local_ip  in  32  own IPv4 address, quasi-static.
- m_valid  out  1  parsed packet available.
- m_ready  in  1  consumer accepts the packet.
- m_oper  out  1  0 = request, 1 = reply.
- m_sha  out  48  sender MAC.
- m_spa  out  32  sender IP.
- m_tha  out  48  target MAC.
- m_tpa  out  32  target IP.
- drop_pulse  out  1  one-cycle strobe per dropped packet.
- drop_cnt  out  CNT_W  saturating count of dropped packets.

Function
REQ-006 SHALL advance only on cycles with data_valid=1; gaps stall parsing with all state held.
REQ-007 SHALL use byte index 0..27, MSB first: HTYPE 0-1, PTYPE 2-3, HLEN 4, PLEN 5, OPER 6-7, SHA 8-13, SPA 14-17, THA 18-23, TPA 24-27.
REQ-008 SHALL use FSM states IDLE, HDR (bytes 0-7), SHA, SPA, THA, TPA, SKIP and DISCARD, with a 5-bit byte counter.
REQ-009 SHALL leave IDLE only on data_valid & eth_type_arp_valid, consuming that byte as index 0; eth_type_arp_valid SHALL be ignored outside IDLE.
REQ-010 SHALL check HTYPE=0x0001, PTYPE=0x0800, HLEN=0x06, PLEN=0x04 and OPER in {1,2}; a mismatch SHALL be detected on the byte that completes the field.
REQ-011 SHALL treat these as errors: OPER=2 with ACCEPT_REPLY=0; THA not all-zero with REQUIRE_ZERO_THA=1 and OPER=1; TPA not equal to local_ip with CHECK_TPA=1; data_last on any byte with index below 27.
REQ-012 On error SHALL drop the packet: drop_pulse=1 for one cycle, then go to IDLE if that byte has data_last, else to DISCARD.
REQ-013 Byte 27 accepted without error SHALL load m_oper/m_sha/m_spa/m_tha/m_tpa and raise m_valid on the next clock edge (1-cycle latency).
REQ-014 After byte 27: data_last on byte 27 SHALL go to IDLE, otherwise to SKIP; SKIP and DISCARD SHALL stay until data_last and then go to IDLE.
REQ-015 Output handshake: m_valid stays 1 and all m_* outputs stay stable until m_valid & m_ready; the transfer completes on that edge and m_valid drops unless a new load happens on the same edge.
REQ-016 If a good packet completes while m_valid=1 and m_ready=0, it SHALL be dropped (REQ-012) and the held output SHALL be unchanged; if m_ready=1 on that cycle, the new packet SHALL load.
REQ-017 drop_cnt SHALL increment by 1 per drop_pulse and saturate at 2^CNT_W-1.
REQ-018 Parsing SHALL be independent of m_ready; data_in is never back-pressured.

Reset
REQ-019 aresetn=0 SHALL asynchronously force state to IDLE, counter to 0, and m_valid, drop_pulse, drop_cnt, m_oper, m_sha, m_spa, m_tha, m_tpa to 0.
REQ-020 Reset mid-packet SHALL discard the partial packet without a drop_pulse; parsing SHALL restart only at the next eth_type_arp_valid.

Verification
REQ-021 Request: SHA 02:00:00:00:00:01, SPA 192.168.1.10, THA 0, TPA = local_ip 192.168.1.20, padded to 46 bytes -> m_valid one cycle after byte 27, m_oper=0, fields exact, drop_cnt=0.
REQ-022 Same request with data_valid low for 3 cycles between every byte -> identical outputs; m_valid one cycle after the last-accepted byte 27.
REQ-023 TPA=192.168.1.99 with CHECK_TPA=1 -> no m_valid, one drop_pulse, drop_cnt=1, DISCARD until data_last; the next good packet parses normally.
REQ-024 PTYPE=0x86DD, then data_last at byte 12 in a second packet -> two drop_pulses, drop_cnt=2, FSM in IDLE after each.
REQ-025 Two good packets back-to-back with m_ready=0 -> first held stable, second dropped (drop_cnt=1); m_ready=1 -> first transferred, m_valid=0.
REQ-026 aresetn low at byte 15 -> all outputs 0 immediately, no drop_pulse; the next packet parses correctly. With CNT_W=2 and 5 drops -> drop_cnt=3.
